prog_loader_ctrl: RTL and testbench
===================================

// Module: prog_loader_ctrl
// PURPOSE
//  Frame-level controller for serial program download into instruction/data memory.
//  Parses a byte stream (sync, word count, payload, checksum) and packs payload into 32-bit words.
//  Owns the memory port while loading and holds the CPU until a good image is written.
//  Sits between the UART byte receiver and the memory port mux in front of the CPU.
// PARAMETERS
//  ADDR_WIDTH  10       word-address width of target memory (depth = 2**ADDR_WIDTH words)
//  SYNC_BYTE   8'hA5    frame start marker
//  TIMEOUT     20'd1000000  max clkMem cycles between payload bytes before abort
// PORTS
//  clkMem     in   1           memory clock; sole clock
//  rstn       in   1           asynchronous, active-low reset
//  byteIn     in   8           received byte
//  byteValid  in   1           1-cycle strobe, byteIn valid
//  cpuAddr    in   ADDR_WIDTH  CPU word address
//  cpuDin     in   32          CPU write data
//  cpuWe      in   4           CPU byte write enables
//  cpuEn      in   1           CPU memory enable
//  memAddr    out  ADDR_WIDTH  memory word address
//  memDin     out  32          memory write data
//  memWe      out  4           memory byte write enables
//  memEn      out  1           memory enable
//  cpuHold    out  1           1 = CPU held in reset
//  busy       out  1           frame in progress
//  loadDone   out  1           last frame completed with good checksum (sticky)
//  loadErr    out  1           last frame aborted (sticky)
// BEHAVIOUR
//  Reset: state IDLE; cpuHold=0, busy=0, loadDone=0, loadErr=0; word reg=0, addr=0, byte count=0.
//  Frame: SYNC_BYTE, CNT_LO, CNT_HI (N words, 16b LE), 4*N payload bytes, CSUM (8b sum of payload mod 256).
//  FSM: IDLE -> CNT_LO -> CNT_HI -> DATA -> CSUM -> DONE; any -> ERROR on abort.
//   IDLE/DONE/ERROR: byteValid with byteIn==SYNC_BYTE -> CNT_LO; set cpuHold=1, busy=1; clear loadDone/loadErr;
//     other bytes ignored.
//   CNT_LO: latch low byte. CNT_HI: latch high byte; N > 2**ADDR_WIDTH -> ERROR; N==0 -> CSUM; else DATA.
//   DATA: bytes shift in LE (1st byte -> [7:0]); 4th byte -> registered write next cycle:
//     memWe=4'hF, memEn=1, memAddr=word index (0..N-1), memDin=packed word; exactly 1 cycle per word.
//     After word N written -> CSUM.
//   CSUM: byteIn==running sum -> DONE (loadDone=1, cpuHold=0, busy=0); else ERROR.
//   ERROR: loadErr=1, busy=0, cpuHold stays 1 (never release CPU on corrupt image).
//  Timeout: in CNT_LO..CSUM, idle counter counts cycles w/o byteValid, clears on byteValid;
//    reaching TIMEOUT -> ERROR.
//  Port mux: cpuHold=1 -> mem* driven by controller (memEn=1 only on write cycle, else 0);
//    cpuHold=0 -> mem* = cpu* combinationally.
//  Address never wraps: N capped by depth check; word index is ADDR_WIDTH+1 bits internally.
//  byteValid on the write cycle is accepted normally (next word begins; no byte dropped).
//  SYNC_BYTE inside payload/count is data, not restart.
//  rstn low mid-frame: immediate return to reset values; partial memory contents left as is.
// TESTING
//  N=2, payload 01..08, csum 8'h24 -> writes [0]=32'h04030201, [1]=32'h08070605; loadDone=1; cpuHold falls.
//  N=1, payload 11 22 33 44, csum 8'h00 -> one write [0]=32'h44332211, then loadErr=1, cpuHold stays 1.
//  N=0, csum 8'h00 -> no memWe pulses; loadDone=1.
//  ADDR_WIDTH=10, N=1025 -> ERROR right after CNT_HI; no writes.
//  Stall TIMEOUT cycles after 2nd payload byte -> loadErr=1; later good frame -> loadDone=1, loadErr=0.
//  Back-to-back byteValid every cycle, N=4 -> 4 single-cycle writes at addr 0..3; cpu* ignored while held.

Source files
------------

// File: rtl/prog_loader_ctrl_if.sv
// Byte stream, CPU memory request and shared memory port bundle for the program loader.
interface prog_loader_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 10
) ();
    logic [7:0]            byteIn;
    logic                  byteValid;
    logic [ADDR_WIDTH-1:0] cpuAddr;
    logic [31:0]           cpuDin;
    logic [3:0]            cpuWe;
    logic                  cpuEn;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [31:0]           memDin;
    logic [3:0]            memWe;
    logic                  memEn;
    logic                  cpuHold;
    logic                  busy;
    logic                  loadDone;
    logic                  loadErr;

    modport master (
        input  byteIn, byteValid, cpuAddr, cpuDin, cpuWe, cpuEn,
        output memAddr, memDin, memWe, memEn, cpuHold, busy, loadDone, loadErr
    );

    modport slave (
        output byteIn, byteValid, cpuAddr, cpuDin, cpuWe, cpuEn,
        input  memAddr, memDin, memWe, memEn, cpuHold, busy, loadDone, loadErr
    );
endinterface

// File: rtl/prog_loader_ctrl.sv
// Serial program download controller: parses sync/count/payload/checksum frames,
// packs payload into 32-bit memory writes and holds the CPU until a good image lands.
module prog_loader_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [19:0] TIMEOUT    = 20'd1000000
) (
    input logic                clkMem,
    input logic                rstn,
    prog_loader_ctrl_if.master bus
);
    localparam int unsigned IDX_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR} stateT;

    stateT                 state, stateNext;
    logic [15:0]           wordCnt, wordCntNext;
    logic [IDX_W-1:0]      wordIdx, wordIdxNext;
    logic [1:0]            byteCnt, byteCntNext;
    logic [23:0]           shiftReg, shiftNext;
    logic [7:0]            sum, sumNext;
    logic [19:0]           idleCnt, idleNext;
    logic                  wrEn, wrEnNext;
    logic [ADDR_WIDTH-1:0] wrAddr, wrAddrNext;
    logic [31:0]           wrData, wrDataNext;
    logic                  hold, holdNext;
    logic                  busyR, busyNext;
    logic                  done, doneNext;
    logic                  err, errNext;
    logic [15:0]           cntRx;
    logic                  inFrame;

    always_ff @(posedge clkMem or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wordCnt  <= '0;
            wordIdx  <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
            sum      <= '0;
            idleCnt  <= '0;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            hold     <= 1'b0;
            busyR    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= stateNext;
            wordCnt  <= wordCntNext;
            wordIdx  <= wordIdxNext;
            byteCnt  <= byteCntNext;
            shiftReg <= shiftNext;
            sum      <= sumNext;
            idleCnt  <= idleNext;
            wrEn     <= wrEnNext;
            wrAddr   <= wrAddrNext;
            wrData   <= wrDataNext;
            hold     <= holdNext;
            busyR    <= busyNext;
            done     <= doneNext;
            err      <= errNext;
        end
    end

    always_comb begin
        stateNext   = state;
        wordCntNext = wordCnt;
        wordIdxNext = wordIdx;
        byteCntNext = byteCnt;
        shiftNext   = shiftReg;
        sumNext     = sum;
        idleNext    = idleCnt;
        wrEnNext    = 1'b0;
        wrAddrNext  = wrAddr;
        wrDataNext  = wrData;
        holdNext    = hold;
        busyNext    = busyR;
        doneNext    = done;
        errNext     = err;
        cntRx       = {bus.byteIn, wordCnt[7:0]};
        inFrame     = (state == CNT_LO) || (state == CNT_HI) || (state == DATA) || (state == CSUM);

        unique case (state)
            IDLE, DONE, ERROR: begin
                if (bus.byteValid && bus.byteIn == SYNC_BYTE) begin
                    stateNext   = CNT_LO;
                    holdNext    = 1'b1;
                    busyNext    = 1'b1;
                    doneNext    = 1'b0;
                    errNext     = 1'b0;
                    sumNext     = '0;
                    idleNext    = '0;
                    wordIdxNext = '0;
                    byteCntNext = '0;
                end
            end
            CNT_LO: begin
                if (bus.byteValid) begin
                    wordCntNext[7:0] = bus.byteIn;
                    stateNext        = CNT_HI;
                end
            end
            CNT_HI: begin
                if (bus.byteValid) begin
                    wordCntNext = cntRx;
                    if (32'(cntRx) > DEPTH) stateNext = ERROR;
                    else if (cntRx == 16'd0) stateNext = CSUM;
                    else stateNext = DATA;
                end
            end
            DATA: begin
                if (bus.byteValid) begin
                    sumNext     = sum + bus.byteIn;
                    byteCntNext = byteCnt + 2'd1;
                    shiftNext   = {bus.byteIn, shiftReg[23:8]};
                    if (byteCnt == 2'd3) begin
                        // Write goes out next cycle from dedicated regs so the shifter keeps accepting.
                        wrEnNext    = 1'b1;
                        wrAddrNext  = wordIdx[ADDR_WIDTH-1:0];
                        wrDataNext  = {bus.byteIn, shiftReg};
                        wordIdxNext = wordIdx + IDX_W'(1);
                        if (32'(wordIdx) + 32'd1 == 32'(wordCnt)) stateNext = CSUM;
                    end
                end
            end
            CSUM: begin
                if (bus.byteValid) begin
                    if (bus.byteIn == sum) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                        holdNext  = 1'b0;
                        busyNext  = 1'b0;
                    end else begin
                        stateNext = ERROR;
                    end
                end
            end
            default: ;
        endcase

        if (inFrame) begin
            if (bus.byteValid) begin
                idleNext = '0;
            end else begin
                idleNext = idleCnt + 20'd1;
                if (idleNext == TIMEOUT) stateNext = ERROR;
            end
        end

        // CPU stays held on abort: the image in memory is not trustworthy.
        if (stateNext == ERROR && state != ERROR) begin
            errNext  = 1'b1;
            busyNext = 1'b0;
        end
    end

    assign bus.memAddr  = hold ? wrAddr : bus.cpuAddr;
    assign bus.memDin   = hold ? wrData : bus.cpuDin;
    assign bus.memWe    = hold ? {4{wrEn}} : bus.cpuWe;
    assign bus.memEn    = hold ? wrEn : bus.cpuEn;
    assign bus.cpuHold  = hold;
    assign bus.busy     = busyR;
    assign bus.loadDone = done;
    assign bus.loadErr  = err;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Scoreboard bench for prog_loader_ctrl: expected memory writes are queued as payload is sent.
module tb_prog_loader_ctrl;
    localparam int unsigned AW   = 10;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [19:0] TMO  = 20'd40;

    logic clkMem = 1'b0;
    logic rstn;
    always #5 clkMem = ~clkMem;

    prog_loader_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    prog_loader_ctrl #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
        .clkMem(clkMem),
        .rstn  (rstn),
        .bus   (bus)
    );

    int cmpCnt = 0;
    int errCnt = 0;
    logic [AW+31:0] expQ [$];
    logic [7:0]     payQ [$];

    task automatic checkEq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        cmpCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory port monitor: every write while held must match the next queued word.
    always @(negedge clkMem) begin
        if (rstn && bus.cpuHold) begin
            if (bus.memEn) begin
                checkEq("wrWe", 64'(bus.memWe), 64'hF);
                if (expQ.size() == 0) begin
                    checkEq("wrUnexpected", 64'(expQ.size()), 64'd1);
                end else begin
                    checkEq("wrAddrData", 64'({bus.memAddr, bus.memDin}), 64'(expQ.pop_front()));
                end
            end else begin
                checkEq("idleWe", 64'(bus.memWe), 64'h0);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap);
        bus.byteIn    = b;
        bus.byteValid = 1'b1;
        @(posedge clkMem); #1;
        bus.byteValid = 1'b0;
        repeat (gap) begin
            @(posedge clkMem); #1;
        end
    endtask

    function automatic logic [7:0] paySum();
        logic [7:0] s = 8'h00;
        foreach (payQ[i]) s = s + payQ[i];
        return s;
    endfunction

    task automatic sendFrame(input logic [15:0] n, input logic [7:0] csum, input int gap);
        sendByte(SYNC, gap);
        checkEq("holdAfterSync", 64'(bus.cpuHold), 64'd1);
        checkEq("busyAfterSync", 64'(bus.busy), 64'd1);
        sendByte(n[7:0], gap);
        sendByte(n[15:8], gap);
        for (int i = 0; i < payQ.size(); i++) begin
            if (i % 4 == 3)
                expQ.push_back({AW'(i / 4), payQ[i], payQ[i-1], payQ[i-2], payQ[i-3]});
            sendByte(payQ[i], gap);
        end
        sendByte(csum, gap);
        checkEq("wrDrained", 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkStatus(input string t, input logic h, input logic b, input logic d, input logic e);
        checkEq({t, ".cpuHold"},  64'(bus.cpuHold),  64'(h));
        checkEq({t, ".busy"},     64'(bus.busy),     64'(b));
        checkEq({t, ".loadDone"}, 64'(bus.loadDone), 64'(d));
        checkEq({t, ".loadErr"},  64'(bus.loadErr),  64'(e));
    endtask

    task automatic checkPass(input string t);
        bus.cpuAddr = AW'($urandom);
        bus.cpuDin  = $urandom;
        bus.cpuWe   = 4'($urandom);
        bus.cpuEn   = 1'($urandom);
        #1;
        checkEq({t, ".addr"}, 64'(bus.memAddr), 64'(bus.cpuAddr));
        checkEq({t, ".din"},  64'(bus.memDin),  64'(bus.cpuDin));
        checkEq({t, ".we"},   64'(bus.memWe),   64'(bus.cpuWe));
        checkEq({t, ".en"},   64'(bus.memEn),   64'(bus.cpuEn));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b0;
        bus.byteIn    = 8'h00;
        bus.byteValid = 1'b0;
        bus.cpuAddr   = '0;
        bus.cpuDin    = '0;
        bus.cpuWe     = '0;
        bus.cpuEn     = 1'b0;
        repeat (3) @(posedge clkMem);
        #1;
        checkStatus("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkPass("resetPass");
        rstn = 1'b1;
        @(posedge clkMem); #1;

        payQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        sendFrame(16'd2, 8'h24, 0);
        checkStatus("goodN2", 1'b0, 1'b0, 1'b1, 1'b0);

        payQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        sendFrame(16'd1, 8'h00, 1);
        checkStatus("badCsum", 1'b1, 1'b0, 1'b0, 1'b1);

        payQ.delete();
        sendFrame(16'd0, 8'h00, 0);
        checkStatus("zeroN", 1'b0, 1'b0, 1'b1, 1'b0);

        sendByte(SYNC, 0);
        sendByte(8'h01, 0);
        sendByte(8'h04, 0);
        checkStatus("ovf1025", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) sendByte(8'(i + 1), 0);
        checkStatus("ovfIgnore", 1'b1, 1'b0, 1'b0, 1'b1);

        payQ.delete();
        for (int i = 0; i < 4 * (1 << AW); i++) payQ.push_back(8'($urandom));
        sendFrame(16'(1 << AW), paySum(), 0);
        checkStatus("fullDepth", 1'b0, 1'b0, 1'b1, 1'b0);

        sendByte(SYNC, 0);
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        sendByte(8'h10, 0);
        sendByte(8'h20, 0);
        repeat (int'(TMO) - 1) begin
            @(posedge clkMem); #1;
        end
        checkStatus("preTimeout", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clkMem); #1;
        checkStatus("timeout", 1'b1, 1'b0, 1'b0, 1'b1);

        payQ = '{SYNC, SYNC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, SYNC};
        sendFrame(16'd2, paySum(), int'(TMO) - 1);
        checkStatus("slowSyncData", 1'b0, 1'b0, 1'b1, 1'b0);

        bus.cpuAddr = '1;
        bus.cpuDin  = 32'hDEADBEEF;
        bus.cpuWe   = 4'hF;
        bus.cpuEn   = 1'b1;
        payQ.delete();
        for (int i = 0; i < 16; i++) payQ.push_back(8'($urandom));
        sendFrame(16'd4, paySum(), 0);
        checkStatus("backToBack", 1'b0, 1'b0, 1'b1, 1'b0);
        checkPass("releasedPass");

        sendByte(SYNC, 0);
        sendByte(8'h03, 0);
        sendByte(8'h00, 0);
        sendByte(8'h55, 0);
        sendByte(8'h66, 0);
        sendByte(8'h77, 0);
        rstn = 1'b0;
        #1;
        checkStatus("rstMid", 1'b0, 1'b0, 1'b0, 1'b0);
        checkPass("rstMidPass");
        repeat (2) @(posedge clkMem);
        #1;
        rstn = 1'b1;
        @(posedge clkMem); #1;

        payQ = '{8'hF0, 8'hE1, 8'hD2, 8'hC3};
        sendFrame(16'd1, paySum(), 0);
        checkStatus("afterRst", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end
endmodule
